// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit controller: FSM state encoding and
// parity type selectors.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Bus bundle between the UART transmit controller, its requester and the
// downstream serializer. The slave modport is the controller side.
interface uart_tx_ctrl_if;

    // Handshake: DATA_VALID is a one-cycle request with no ready signal. It is
    // accepted only when the controller is in IDLE or STOP; in any other state
    // it is dropped (no queueing). busy=1 marks a frame in progress, and
    // ser_done is only meaningful while ser_en=1.
    logic       DATA_VALID;
    logic [7:0] P_DATA;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic [7:0] DATA_LATCHED;
    logic       TX_OUT;
    logic       busy;
    uart_tx_pkg::state_t dbg_state;

    modport master (
        output DATA_VALID, P_DATA, PAR_EN, PAR_TYP, ser_data, ser_done,
        input  ser_en, DATA_LATCHED, TX_OUT, busy, dbg_state
    );

    modport slave (
        input  DATA_VALID, P_DATA, PAR_EN, PAR_TYP, ser_data, ser_done,
        output ser_en, DATA_LATCHED, TX_OUT, busy, dbg_state
    );

endinterface

// File: rtl/uart_tx_ctrl_parity.sv
// Parity generator: even parity is the XOR of the byte, odd parity its inverse.
module parity_calc
    import uart_tx_pkg::*;
(
    input  logic [7:0] data,
    input  logic       par_typ,
    output logic       par
);

    assign par = (^data) ^ (par_typ == ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, serializer-driven data bits,
// optional parity bit (build macro UART_TX_PARITY_EN), stop bit.
module uart_tx_ctrl
    import uart_tx_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    uart_tx_ctrl_if.slave bus
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] data_latched;
    logic       accept;
    logic       tx_out;
    logic       busy;
    logic       ser_en;

    // A new byte is taken only between frames or on the stop bit (back-to-back).
    assign accept = bus.DATA_VALID && ((state == IDLE) || (state == STOP));

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;
    logic par_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_q  <= 1'b0;
            par_typ_q <= EVEN;
        end else if (accept) begin
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
        end
    end

    // Derived from the held byte and type, so it is fixed for the whole frame
    // and reads 0 out of reset.
    parity_calc u_parity (
        .data    (data_latched),
        .par_typ (par_typ_q),
        .par     (par_bit)
    );
`else
    logic unused_par_inputs;
    assign unused_par_inputs = bus.PAR_EN ^ bus.PAR_TYP;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_latched <= 8'h00;
        end else if (accept) begin
            data_latched <= bus.P_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.DATA_VALID) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = DATA;
            end
            DATA: begin
                if (bus.ser_done) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = par_en_q ? PARITY : STOP;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                state_nxt = STOP;
            end
`endif
            STOP: begin
                state_nxt = bus.DATA_VALID ? START : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_out = 1'b1;
        busy   = 1'b0;
        ser_en = 1'b0;
        case (state)
            IDLE: begin
                tx_out = 1'b1;
            end
            START: begin
                tx_out = 1'b0;
                busy   = 1'b1;
            end
            DATA: begin
                tx_out = bus.ser_data;
                busy   = 1'b1;
                ser_en = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_out = par_bit;
                busy   = 1'b1;
            end
`endif
            STOP: begin
                tx_out = 1'b1;
                busy   = 1'b1;
            end
            default: begin
                tx_out = 1'b1;
            end
        endcase
    end

    assign bus.TX_OUT       = tx_out;
    assign bus.busy         = busy;
    assign bus.ser_en       = ser_en;
    assign bus.DATA_LATCHED = data_latched;
    assign bus.dbg_state    = state;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frame-level reference model plus
// directed frames with hand-computed line sequences.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    uart_tx_ctrl_if bus ();

    uart_tx_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each entry is one line cycle still to come: bit1 = data slot, bit0 = line level.
    logic [1:0] exp_q[$];
    logic [7:0] exp_latched = 8'h00;

    function automatic void push_frame(input logic [7:0] b, input logic pe, input logic pt);
        exp_q.push_back(2'b00);
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, b[i]});
        if (PAR_BUILT && pe) exp_q.push_back({1'b0, (^b) ^ pt});
        exp_q.push_back(2'b01);
        exp_latched = b;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        exp_latched = 8'h00;
    endfunction

    initial begin
        logic accepting;
        forever begin
            @(posedge clk);
            if (!rst) begin
                model_reset();
            end else begin
                accepting = (bus.DATA_VALID === 1'b1) && (exp_q.size() <= 1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (accepting) push_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        logic exp_tx, exp_busy, exp_en;
        forever begin
            @(negedge clk);
            #2;
            exp_tx   = (exp_q.size() > 0) ? exp_q[0][0] : 1'b1;
            exp_busy = (exp_q.size() > 0);
            exp_en   = (exp_q.size() > 0) ? exp_q[0][1] : 1'b0;
            check("tx_out", {31'b0, bus.TX_OUT}, {31'b0, exp_tx});
            check("busy", {31'b0, bus.busy}, {31'b0, exp_busy});
            check("ser_en", {31'b0, bus.ser_en}, {31'b0, exp_en});
            check("data_latched", {24'b0, bus.DATA_LATCHED}, {24'b0, exp_latched});
        end
    end

    // ---------------- serializer emulation ----------------
    // Shifts the held byte LSB first while enabled; noise on ser_done/ser_data otherwise.
    initial begin
        int idx = 0;
        bus.ser_data = 1'b0;
        bus.ser_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ser_en === 1'b1) begin
                bus.ser_data = bus.DATA_LATCHED[idx[2:0]];
                bus.ser_done = (idx == 7);
                idx++;
            end else begin
                idx = 0;
                bus.ser_data = 1'($urandom_range(0, 1));
                bus.ser_done = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [31:0] cap_tx;
    logic [31:0] cap_busy;
    logic [7:0]  cap_dl [32];

    task automatic drive_idle();
        bus.DATA_VALID = 1'b0;
        bus.P_DATA     = 8'($urandom);
        bus.PAR_EN     = 1'($urandom_range(0, 1));
        bus.PAR_TYP    = 1'($urandom_range(0, 1));
    endtask

    // Requests byte b, optionally pulses a second request b2 during sample cycle inj,
    // and records 32 cycles of line state starting with the first frame cycle.
    task automatic run_frame(input logic [7:0] b, input logic pe, input logic pt,
                             input int inj, input logic [7:0] b2);
        @(negedge clk);
        bus.DATA_VALID = 1'b1;
        bus.P_DATA     = b;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == inj) begin
                bus.DATA_VALID = 1'b1;
                bus.P_DATA     = b2;
                bus.PAR_EN     = 1'b0;
                bus.PAR_TYP    = 1'b0;
            end else begin
                drive_idle();
            end
            #2;
            cap_tx[i]   = bus.TX_OUT;
            cap_busy[i] = bus.busy;
            cap_dl[i]   = bus.DATA_LATCHED;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0;
        bus.DATA_VALID = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_tx", {31'b0, bus.TX_OUT}, 32'd1);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_ser_en", {31'b0, bus.ser_en}, 32'd0);
        check("reset_latched", {24'b0, bus.DATA_LATCHED}, 32'h00);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5 even parity: start, 1,0,1,0,0,1,0,1, parity 0, stop, idle
        run_frame(8'hA5, 1'b1, 1'b0, -1, 8'h00);
        check("a5_even_line", {20'b0, cap_tx[11:0]}, PAR_BUILT ? 32'hD4A : 32'hF4A);
        check("a5_even_busy", $countones(cap_busy), PAR_BUILT ? 32'd11 : 32'd10);

        // 0xA5 odd parity: parity slot becomes 1
        run_frame(8'hA5, 1'b1, 1'b1, -1, 8'h00);
        check("a5_odd_line", {20'b0, cap_tx[11:0]}, 32'hF4A);

        // 0x01 without parity: start + 8 data + stop
        run_frame(8'h01, 1'b0, 1'b0, -1, 8'h00);
        check("01_nopar_line", {20'b0, cap_tx[11:0]}, 32'hE02);
        check("01_nopar_busy", $countones(cap_busy), 32'd10);

        // 0x3C requested mid-DATA is dropped
        run_frame(8'hA5, 1'b0, 1'b0, 3, 8'h3C);
        check("ignore_latched", {24'b0, cap_dl[20]}, 32'hA5);
        check("ignore_busy", $countones(cap_busy), 32'd10);

        // 0x55 requested in STOP starts the next frame with no idle gap
        run_frame(8'hA5, 1'b0, 1'b0, 9, 8'h55);
        check("b2b_start", {31'b0, cap_tx[10]}, 32'd0);
        check("b2b_latched", {24'b0, cap_dl[10]}, 32'h55);
        check("b2b_busy", cap_busy[19:0], 32'hFFFFF);
        check("b2b_busy_total", $countones(cap_busy), 32'd20);

        // reset mid-DATA aborts the frame immediately
        @(negedge clk);
        bus.DATA_VALID = 1'b1;
        bus.P_DATA     = 8'h3C;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            drive_idle();
        end
        check("pre_reset_ser_en", {31'b0, bus.ser_en}, 32'd1);
        rst = 1'b0;
        model_reset();
        #1;
        check("midreset_tx", {31'b0, bus.TX_OUT}, 32'd1);
        check("midreset_busy", {31'b0, bus.busy}, 32'd0);
        check("midreset_ser_en", {31'b0, bus.ser_en}, 32'd0);
        check("midreset_latched", {24'b0, bus.DATA_LATCHED}, 32'h00);
        @(negedge clk);
        rst = 1'b1;
        run_frame(8'h81, 1'b1, 1'b0, -1, 8'h00);
        check("81_line", {20'b0, cap_tx[11:0]}, PAR_BUILT ? 32'hD02 : 32'hF02);
        check("81_busy", $countones(cap_busy), PAR_BUILT ? 32'd11 : 32'd10);

        // randomized traffic with occasional resets, checked by the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                @(negedge clk);
                drive_idle();
                bus.DATA_VALID = ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clk);
        drive_idle();
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL expose: clk  input  1  system clock, all state updates on rising edge.
REQ-002 The block SHALL expose: rst  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL expose: DATA_VALID  input  1  one-cycle request to send P_DATA.
REQ-004 The block SHALL expose: P_DATA  input  8  byte to transmit, sampled only on acceptance.
REQ-005 The block SHALL expose: PAR_EN  input  1  parity bit inserted when 1, sampled on acceptance.
REQ-006 The block SHALL expose: PAR_TYP  input  1  0 = even, 1 = odd, sampled on acceptance.
REQ-007 The block SHALL expose: ser_data  input  1  serial bit from the downstream serializer.
REQ-008 The block SHALL expose: ser_done  input  1  serializer last-bit indication.
REQ-009 The block SHALL expose: ser_en  output  1  serializer enable.
REQ-010 The block SHALL expose: DATA_LATCHED  output  8  held byte driving the serializer P_DATA.
REQ-011 The block SHALL expose: TX_OUT  output  1  UART line.
REQ-012 The block SHALL expose: busy  output  1  frame in progress.

Function
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP; state is held in a register; TX_OUT, ser_en and busy SHALL be decoded combinationally from the current state.
REQ-014 IDLE: TX_OUT=1, busy=0, ser_en=0; DATA_VALID=1 SHALL latch P_DATA into DATA_LATCHED, latch PAR_EN and PAR_TYP, compute par_bit, and go to START.
REQ-015 START SHALL last exactly one cycle with TX_OUT=0 and busy=1, then go to DATA.
REQ-016 DATA: ser_en=1, TX_OUT=ser_data, busy=1; the state SHALL be held until ser_done=1 is sampled.
REQ-017 On ser_done=1 in DATA, the next state SHALL be PARITY if the latched PAR_EN=1, else STOP.
REQ-018 PARITY SHALL last one cycle with TX_OUT=par_bit; par_bit = XOR of DATA_LATCHED for even, its inverse for odd.
REQ-019 STOP SHALL last one cycle with TX_OUT=1 and busy=1; if DATA_VALID=1 in STOP, the block SHALL latch the new byte and go directly to START (back-to-back), else go to IDLE.
REQ-020 DATA_VALID in START, DATA or PARITY SHALL be ignored: no latch, no queueing, DATA_LATCHED unchanged.
REQ-021 ser_done outside DATA SHALL be ignored.
REQ-022 DATA_LATCHED SHALL stay stable from acceptance until the next acceptance.

Reset
REQ-023 rst=0 SHALL immediately force IDLE, DATA_LATCHED=0x00, latched PAR_EN=0, latched PAR_TYP=0 and par_bit=0, giving TX_OUT=1, busy=0 and ser_en=0, regardless of the current state.
REQ-024 A reset asserted mid-frame SHALL abort the frame; after release, the first DATA_VALID SHALL start a fresh frame.

Configuration
REQ-025 Macro UART_TX_PARITY_EN: when defined, the PARITY state and parity logic SHALL exist as specified.
REQ-026 When UART_TX_PARITY_EN is not defined, PARITY SHALL not be synthesised; PAR_EN and PAR_TYP SHALL remain as ports but be ignored; DATA SHALL always go to STOP.

Structure
REQ-027 Package uart_tx_pkg SHALL hold the state encoding constants (IDLE=0 .. STOP=4, 3-bit) and the parity type constants EVEN=0 and ODD=1.
REQ-028 Parity computation SHALL be a sub-module parity_calc (8-bit data, type in, 1-bit parity out), instantiated only under UART_TX_PARITY_EN.

Verification
REQ-029 Macro defined, 0xA5 with PAR_EN=1, PAR_TYP=0 -> TX_OUT sequence start 0, serializer bits, parity 0, stop 1; busy high from the cycle after acceptance until the end of STOP.
REQ-030 0xA5 with PAR_EN=1, PAR_TYP=1 -> parity bit 1.
REQ-031 0x01 with PAR_EN=0 -> DATA goes to STOP with no parity cycle; frame length is start + data + 1 cycle.
REQ-032 DATA_VALID pulse with 0x3C during DATA -> ignored; DATA_LATCHED keeps the first byte; no second frame is sent.
REQ-033 DATA_VALID with 0x55 asserted in STOP -> next cycle is START with DATA_LATCHED=0x55 and no IDLE cycle between frames.
REQ-034 rst pulsed low mid-DATA -> TX_OUT=1, busy=0 and ser_en=0 in the same cycle; a subsequent 0x81 request sends a complete, correct frame.
